logs_pwm_demod: RTL

LOGS_PWM_DEMOD -- requirements
Module: logs_pwm_demod

---
 rtl/logs_pwm_demod.sv | 87 ++++++++
 1 files changed

// File: rtl/logs_pwm_demod.sv
// logs_pwm_demod: counts high cycles of audio_in over each 2^K-clock frame into a K+1-bit sample.
// Sample valid the cycle after frame end, held until consumed, and overwritten with sticky overrun if unread; LOGS_PWM_DEMOD_SYNC_EN adds a 2-flop synchronizer.
module logs_pwm_demod #(
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         audio_in,
    input  logic         frame_sync,
    input  logic         sample_ready,
    output logic [K:0]   sample,
    output logic         sample_valid,
    output logic         overrun
);

    logic           r_s;
    logic [K-1:0]   r_cnt;
    logic [K:0]     r_acc;
    logic [K:0]     r_sample;
    logic           r_valid;
    logic           r_overrun;

    logic           w_frame_end;
    logic [K:0]     w_acc_next;

`ifdef LOGS_PWM_DEMOD_SYNC_EN
    logic [1:0]     r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], audio_in};
            r_s    <= r_sync[1];
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= 1'b0;
        end else begin
            r_s <= audio_in;
        end
    end
`endif

    // frame_sync on the last frame cycle suppresses the load entirely
    assign w_frame_end = (r_cnt == {K{1'b1}}) && !frame_sync;
    assign w_acc_next  = r_acc + {{K{1'b0}}, r_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (frame_sync) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else begin
            r_cnt <= r_cnt + K'(1);
            r_acc <= w_frame_end ? '0 : w_acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_frame_end) begin
                r_sample <= w_acc_next;
                r_valid  <= 1'b1;
                if (r_valid && !sample_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule
